// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared types and helpers for the iterative RV32M multiplier.
//               mul_op_e    - MUL/MULH/MULHSU/MULHU opcode (2 bits)
//               mul_state_e - IDLE/CALC/FIX/DONE sequencer states
//               is_signed_a / is_signed_b - operand signedness per opcode
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mul_state_e;

    // rs1 is treated as signed for MULH and MULHSU.
    function automatic logic is_signed_a(input mul_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    // rs2 is treated as signed for MULH only. MUL needs no sign handling
    // because the low half of the product is the same either way.
    function automatic logic is_signed_b(input mul_op_e op);
        return (op == OP_MULH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_digit_row.sv
`default_nettype none
// ============================================================================
// Module      : mul_digit_row
// Description : Combinational unsigned XLEN x DIGIT array multiplier built
//               from rows of half/full adder cells.
// Ports       : a [XLEN-1:0]        multiplicand (magnitude)
//               d [DIGIT-1:0]       multiplier digit
//               p [XLEN+DIGIT-1:0]  full unsigned product a*d
// Revision    : 1.0 - initial release
// ============================================================================
module mul_digit_row #(
    parameter int XLEN  = 32,
    parameter int DIGIT = 4
) (
    input  logic [XLEN-1:0]       a,
    input  logic [DIGIT-1:0]      d,
    output logic [XLEN+DIGIT-1:0] p
);

    localparam int W = XLEN + DIGIT;

    // Partial product rows, each pre-shifted to its bit weight.
    wire [W-1:0] pp  [DIGIT];
    // Running sum after accumulating rows 0..j.
    wire [W-1:0] sum [DIGIT];

    genvar j, i;

    for (j = 0; j < DIGIT; j++) begin : g_pp
        assign pp[j] = W'(a & {XLEN{d[j]}}) << j;
    end

    assign sum[0] = pp[0];

    // Each row ripples pp[j] into the running sum. The product of an XLEN-bit
    // value and a DIGIT-bit value fits in W bits, so the carry out of the top
    // cell is always zero and is not generated.
    for (j = 1; j < DIGIT; j++) begin : g_row
        wire [W-2:0] cy;
        for (i = 0; i < W; i++) begin : g_bit
            if (i == 0) begin : g_ha
                assign sum[j][i] = sum[j-1][i] ^ pp[j][i];
                assign cy[i]     = sum[j-1][i] & pp[j][i];
            end else if (i < W - 1) begin : g_fa
                assign sum[j][i] = sum[j-1][i] ^ pp[j][i] ^ cy[i-1];
                assign cy[i]     = (sum[j-1][i] & pp[j][i])
                                 | (sum[j-1][i] & cy[i-1])
                                 | (pp[j][i]    & cy[i-1]);
            end else begin : g_top
                assign sum[j][i] = sum[j-1][i] ^ pp[j][i] ^ cy[i-1];
            end
        end
    end

    assign p = sum[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/mul_unit_iter.sv
`default_nettype none
// ============================================================================
// Module      : mul_unit_iter
// Description : Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU). Retires
//               DIGIT multiplier bits per cycle; result after N+1 cycles,
//               N = XLEN/DIGIT. Valid/ready handshake on both sides.
// Ports       : clk, rst (async, active high), flush (sync abort)
//               in_valid/in_ready, op[1:0], A[XLEN-1:0] (rs1), B (rs2)
//               out_valid/out_ready, S[XLEN-1:0] (selected result half)
// Revision    : 1.0 - initial release
// ============================================================================
module mul_unit_iter
    import mul_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DIGIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] S
);

    localparam int N       = XLEN / DIGIT;
    localparam int AW      = 2 * XLEN;
    localparam int CNT_W   = $clog2(N + 1);
    localparam int SH_W    = $clog2(AW);
    localparam int DIG_LOG = $clog2(DIGIT);

    mul_state_e        state_q,     state_d;
    mul_op_e           op_q,        op_d;
    logic [XLEN-1:0]   a_mag_q,     a_mag_d;
    logic [XLEN-1:0]   b_q,         b_d;
    logic              neg_q,       neg_d;
    logic [AW-1:0]     acc_q,       acc_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [XLEN-1:0]   s_q,         s_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;

    mul_op_e             op_in;
    logic                sign_a;
    logic                sign_b;
    logic [XLEN-1:0]     a_abs;
    logic [XLEN-1:0]     b_abs;
    logic [XLEN+DIGIT-1:0] row_p;
    logic [SH_W-1:0]     shamt;
    logic [AW-1:0]       addend;
    logic [AW-1:0]       fix_val;

    // Operand conditioning: magnitudes plus the sign of the final product.
    // The most negative input maps to 2^(XLEN-1), which is still a valid
    // unsigned XLEN-bit magnitude.
    always_comb begin
        op_in  = mul_op_e'(op);
        sign_a = is_signed_a(op_in) & A[XLEN-1];
        sign_b = is_signed_b(op_in) & B[XLEN-1];
        a_abs  = sign_a ? (~A + 1'b1) : A;
        b_abs  = sign_b ? (~B + 1'b1) : B;
    end

    mul_digit_row #(
        .XLEN  (XLEN),
        .DIGIT (DIGIT)
    ) u_row (
        .a (a_mag_q),
        .d (b_q[DIGIT-1:0]),
        .p (row_p)
    );

    // The partial product is zero-extended to the accumulator width before
    // being weighted by cnt*DIGIT, so no carry can be lost.
    always_comb begin
        shamt   = SH_W'(cnt_q) << DIG_LOG;
        addend  = AW'(row_p) << shamt;
        fix_val = neg_q ? (~acc_q + 1'b1) : acc_q;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_mag_d = a_mag_q;
        b_d     = b_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        s_d     = s_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = op_in;
                    a_mag_d = a_abs;
                    b_d     = b_abs;
                    neg_d   = sign_a ^ sign_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = acc_q + addend;
                b_d   = b_q >> DIGIT;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                acc_d   = fix_val;
                s_d     = (op_q == OP_MUL) ? fix_val[XLEN-1:0] : fix_val[AW-1:XLEN];
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over everything else; an aborted operation must not
        // disturb the last delivered result.
        if (flush) begin
            state_d = ST_IDLE;
            s_d     = s_q;
        end

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            a_mag_q     <= '0;
            b_q         <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            s_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_mag_q     <= a_mag_d;
            b_q         <= b_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign S         = s_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_unit_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mul_unit_iter
// Description : Self-checking bench for mul_unit_iter. Four instances cover
//               XLEN/DIGIT = 32/4, 16/1, 64/2, 64/8. Expected products come
//               from plain wide signed arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_unit_iter;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULH   = 2'd1;
    localparam logic [1:0] OP_MULHSU = 2'd2;
    localparam logic [1:0] OP_MULHU  = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        out_ready;
    logic [1:0]  op;
    logic [3:0]  in_valid;
    logic [31:0] a0, b0;
    logic [15:0] a1, b1;
    logic [63:0] a2, b2, a3, b3;
    wire  [31:0] s0;
    wire  [15:0] s1;
    wire  [63:0] s2, s3;
    wire  [3:0]  in_ready;
    wire  [3:0]  out_valid;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mul_unit_iter #(.XLEN(32), .DIGIT(4)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op(op), .A(a0), .B(b0), .out_valid(out_valid[0]), .out_ready(out_ready), .S(s0));
    mul_unit_iter #(.XLEN(16), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op(op), .A(a1), .B(b1), .out_valid(out_valid[1]), .out_ready(out_ready), .S(s1));
    mul_unit_iter #(.XLEN(64), .DIGIT(2)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .op(op), .A(a2), .B(b2), .out_valid(out_valid[2]), .out_ready(out_ready), .S(s2));
    mul_unit_iter #(.XLEN(64), .DIGIT(8)) u_dut3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .op(op), .A(a3), .B(b3), .out_valid(out_valid[3]), .out_ready(out_ready), .S(s3));

    function automatic int xl(input int k);
        case (k)
            0:       return 32;
            1:       return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int dg(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            2:       return 2;
            default: return 8;
        endcase
    endfunction

    function automatic logic [63:0] mask_of(input int xlen);
        if (xlen == 64) return {64{1'b1}};
        return (64'd1 << xlen) - 64'd1;
    endfunction

    function automatic logic [63:0] get_s(input int k);
        case (k)
            0:       return 64'(s0);
            1:       return 64'(s1);
            2:       return s2;
            default: return s3;
        endcase
    endfunction

    // Exact product of the sign/zero-extended operands, then pick a half.
    function automatic logic [63:0] ref_mul(input int xlen, input logic [1:0] o,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [63:0]         m, am, bm;
        logic signed [127:0] ea, eb, p;
        logic [127:0]        hi;
        m  = mask_of(xlen);
        am = a & m;
        bm = b & m;
        ea = $signed({64'd0, am});
        eb = $signed({64'd0, bm});
        if ((o == OP_MULH || o == OP_MULHSU) && am[xlen-1]) ea = ea - (128'sd1 <<< xlen);
        if ((o == OP_MULH) && bm[xlen-1])                   eb = eb - (128'sd1 <<< xlen);
        p  = ea * eb;
        hi = p >> xlen;
        if (o == OP_MUL) return p[63:0] & m;
        return hi[63:0] & m;
    endfunction

    function automatic logic [63:0] pick(input int xlen);
        logic [63:0] m, r;
        m = mask_of(xlen);
        case ($urandom_range(0, 7))
            0:       r = 64'd0;
            1:       r = m;
            2:       r = 64'd1 << (xlen - 1);
            3:       r = 64'd1;
            default: r = {$urandom, $urandom} & m;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ab(input int k, input logic [63:0] a, input logic [63:0] b);
        case (k)
            0:       begin a0 = a[31:0]; b0 = b[31:0]; end
            1:       begin a1 = a[15:0]; b1 = b[15:0]; end
            2:       begin a2 = a;       b2 = b;       end
            default: begin a3 = a;       b3 = b;       end
        endcase
    endtask

    // Issue one request on instance k and wait out the accept edge.
    task automatic start(input int k, input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        set_ab(k, a, b);
        op          = o;
        in_valid[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic run_op(input int k, input logic [1:0] o, input logic [63:0] a,
                          input logic [63:0] b, input int hold, input string tag);
        int          cyc;
        logic [63:0] exp_s;
        exp_s = ref_mul(xl(k), o, a, b);
        chk({tag, " in_ready_idle"}, 64'(in_ready[k]), 64'd1);
        start(k, o, a, b);
        chk({tag, " in_ready_busy"}, 64'(in_ready[k]), 64'd0);
        cyc = 0;
        while (!out_valid[k] && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(xl(k) / dg(k) + 1));
        chk({tag, " S"}, get_s(k), exp_s);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, " hold out_valid"}, 64'(out_valid[k]), 64'd1);
            chk({tag, " hold S"}, get_s(k), exp_s);
            chk({tag, " hold in_ready"}, 64'(in_ready[k]), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " release out_valid"}, 64'(out_valid[k]), 64'd0);
        chk({tag, " release in_ready"}, 64'(in_ready[k]), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        op        = OP_MUL;
        in_valid  = 4'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        a2 = '0; b2 = '0; a3 = '0; b3 = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset in_ready k%0d", k), 64'(in_ready[k]), 64'd1);
            chk($sformatf("reset out_valid k%0d", k), 64'(out_valid[k]), 64'd0);
            chk($sformatf("reset S k%0d", k), get_s(k), 64'd0);
        end

        run_op(0, OP_MUL,    64'd7,          64'hFFFF_FFFD, 0, "mul_7_m3");
        run_op(0, OP_MULH,   64'h8000_0000,  64'h8000_0000, 0, "mulh_min");
        run_op(0, OP_MULHU,  64'h8000_0000,  64'h8000_0000, 0, "mulhu_min");
        run_op(0, OP_MULHSU, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 0, "mulhsu_m1");
        run_op(0, OP_MULHU,  64'hFFFF_FFFF,  64'hFFFF_FFFF, 5, "mulhu_max_bp");
        run_op(0, OP_MULH,   64'd0,          64'hFFFF_FFFB, 0, "mulh_zero");

        // flush and in_valid in the same IDLE cycle: the request is dropped.
        set_ab(0, 64'd3, 64'd5);
        op          = OP_MUL;
        in_valid[0] = 1'b1;
        flush       = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        flush       = 1'b0;
        chk("flush_vs_valid in_ready", 64'(in_ready[0]), 64'd1);
        @(posedge clk); #1;
        chk("flush_vs_valid still idle", 64'(in_ready[0]), 64'd1);

        // Abort on the third CALC cycle.
        start(0, OP_MUL, 64'd1234, 64'd5678);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush in_ready", 64'(in_ready[0]), 64'd1);
        chk("flush out_valid", 64'(out_valid[0]), 64'd0);
        run_op(0, OP_MUL, 64'd3, 64'd5, 0, "after_flush_3x5");

        // Asynchronous reset mid-CALC, observed before the next clock edge.
        start(0, OP_MULH, 64'd9, 64'd9);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst in_ready", 64'(in_ready[0]), 64'd1);
        chk("async_rst out_valid", 64'(out_valid[0]), 64'd0);
        chk("async_rst S", get_s(0), 64'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst in_ready", 64'(in_ready[0]), 64'd1);
        chk("post_rst out_valid", 64'(out_valid[0]), 64'd0);

        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 30; t++) begin
                logic [1:0]  o;
                logic [63:0] a, b;
                o = 2'($urandom_range(0, 3));
                a = pick(xl(k));
                b = pick(xl(k));
                run_op(k, o, a, b, int'($urandom_range(0, 2)), $sformatf("rnd k%0d t%0d op%0d", k, t, o));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
